// File: rtl/lut_code_pkg.sv
// Shared definitions for the LUT-code unpacker: width defaults, FSM state
// encoding and elaboration-time helpers for beat count and counter width.
package lut_code_pkg;

    localparam int CODE_W_DEF = 2;
    localparam int OUT_W_DEF  = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    // Number of output beats needed to drain one input vector.
    function automatic int num_beats(input int num_codes, input int codes_per_beat);
        return num_codes / codes_per_beat;
    endfunction

    // Beat counter width; never narrower than one bit.
    function automatic int cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/lut_code_unpacker_if.sv
// Handshake bundle between the last LUT layer (vector side) and the
// downstream readout (beat side).
interface lut_code_unpacker_if #(
    parameter int NUM_CODES      = 16,
    parameter int CODE_W         = 2,
    parameter int CODES_PER_BEAT = 4,
    parameter int OUT_W          = 8,
    parameter int BEAT_W         = 2
);
    logic                            in_valid;
    logic                            in_ready;
    logic [NUM_CODES*CODE_W-1:0]     in_data;
    logic                            out_valid;
    logic                            out_ready;
    logic [CODES_PER_BEAT*OUT_W-1:0] out_data;
    logic                            out_last;
    logic [BEAT_W-1:0]               out_beat;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_beat
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, out_beat
    );
endinterface

// File: rtl/lut_code_dequant.sv
// Maps one quantized activation code to its fixed-point value:
// value = code*STEP + OFFSET, wrapped to OUT_W bits.
module lut_code_dequant
    import lut_code_pkg::*;
#(
    parameter int CODE_W = CODE_W_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int STEP   = 32,
    parameter int OFFSET = 16
) (
    input  logic [CODE_W-1:0] code,
    output logic [OUT_W-1:0]  value
);

    localparam logic [OUT_W-1:0] STEP_V   = OUT_W'(STEP);
    localparam logic [OUT_W-1:0] OFFSET_V = OUT_W'(OFFSET);

    // Affine dequantization evaluated entirely at OUT_W bits so it wraps.
    always_comb begin
        value = OUT_W'(code) * STEP_V + OFFSET_V;
    end

endmodule

// File: rtl/lut_code_unpacker.sv
// Captures a packed vector of activation codes in one beat, then streams
// the dequantized values out CODES_PER_BEAT at a time. A new vector may be
// accepted on the same edge as the final beat transfer, so consecutive
// vectors flow without a bubble.
module lut_code_unpacker
    import lut_code_pkg::*;
#(
    parameter int NUM_CODES      = 16,
    parameter int CODE_W         = CODE_W_DEF,
    parameter int CODES_PER_BEAT = 4,
    parameter int OUT_W          = OUT_W_DEF,
    parameter int STEP           = 32,
    parameter int OFFSET         = 16
) (
    input logic                clk,
    input logic                rst,
    lut_code_unpacker_if.slave bus
);

    localparam int NUM_BEATS = num_beats(NUM_CODES, CODES_PER_BEAT);
    localparam int BEAT_W    = cnt_width(NUM_BEATS);
    localparam int VEC_W     = NUM_CODES * CODE_W;
    localparam int BEAT_BITS = CODES_PER_BEAT * CODE_W;
    localparam int DATA_W    = CODES_PER_BEAT * OUT_W;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);
    localparam logic [0:0]        S_IDLE    = ST_IDLE;
    localparam logic [0:0]        S_SEND    = ST_SEND;

    generate
        if ((NUM_CODES % CODES_PER_BEAT) != 0) begin : g_bad_cfg
            $error("lut_code_unpacker: CODES_PER_BEAT must divide NUM_CODES");
        end
    endgenerate

    logic [0:0]        state_r,  state_nxt_s;
    logic [VEC_W-1:0]  vec_r,    vec_nxt_s;
    logic [BEAT_W-1:0] beat_r,   beat_nxt_s;
    logic              valid_r,  valid_nxt_s;
    logic              last_r,   last_nxt_s;
    logic [DATA_W-1:0] data_r,   deq_s;
    logic [BEAT_BITS-1:0] slice_s;
    logic              xfer_s;
    logic              ready_s;
    logic              accept_s;
    logic              load_s;

    // Handshake decode and next-state selection for the vector/beat FSM.
    always_comb begin
        xfer_s      = valid_r && bus.out_ready;
        ready_s     = (state_r == S_IDLE) || (xfer_s && last_r);
        accept_s    = bus.in_valid && ready_s;
        state_nxt_s = state_r;
        vec_nxt_s   = vec_r;
        beat_nxt_s  = beat_r;
        valid_nxt_s = valid_r;
        last_nxt_s  = last_r;
        load_s      = 1'b0;
        if (accept_s) begin
            state_nxt_s = S_SEND;
            vec_nxt_s   = bus.in_data;
            beat_nxt_s  = BEAT_W'(0);
            valid_nxt_s = 1'b1;
            last_nxt_s  = (LAST_BEAT == BEAT_W'(0));
            load_s      = 1'b1;
        end else if (xfer_s) begin
            if (last_r) begin
                state_nxt_s = S_IDLE;
                beat_nxt_s  = BEAT_W'(0);
                valid_nxt_s = 1'b0;
                last_nxt_s  = 1'b0;
            end else begin
                beat_nxt_s  = beat_r + BEAT_W'(1);
                last_nxt_s  = ((beat_r + BEAT_W'(1)) == LAST_BEAT);
                load_s      = 1'b1;
            end
        end else begin
            load_s = 1'b0;
        end
    end

    // Codes belonging to the beat that will be presented after this edge.
    always_comb begin
        slice_s = BEAT_BITS'(vec_nxt_s >> (int'(beat_nxt_s) * BEAT_BITS));
    end

    generate
        for (genvar j = 0; j < CODES_PER_BEAT; j++) begin : g_lane
            lut_code_dequant #(
                .CODE_W (CODE_W),
                .OUT_W  (OUT_W),
                .STEP   (STEP),
                .OFFSET (OFFSET)
            ) u_dequant (
                .code  (slice_s[j*CODE_W +: CODE_W]),
                .value (deq_s[j*OUT_W +: OUT_W])
            );
        end
    endgenerate

    // State, held vector, beat counter and registered output beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            vec_r   <= '0;
            beat_r  <= '0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            data_r  <= '0;
        end else begin
            state_r <= state_nxt_s;
            vec_r   <= vec_nxt_s;
            beat_r  <= beat_nxt_s;
            valid_r <= valid_nxt_s;
            last_r  <= last_nxt_s;
            if (load_s) begin
                data_r <= deq_s;
            end else begin
                data_r <= data_r;
            end
        end
    end

    assign bus.in_ready  = ready_s;
    assign bus.out_valid = valid_r;
    assign bus.out_data  = data_r;
    assign bus.out_last  = last_r;
    assign bus.out_beat  = beat_r;

endmodule

// File: tb/tb_lut_code_unpacker.sv
// Directed bench for lut_code_unpacker: reset state, single vector,
// back-to-back vectors, stalls, mid-vector reset, ignored input and a
// parameter override showing the modulo wrap.
module tb_lut_code_unpacker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    lut_code_unpacker_if #(.NUM_CODES(16), .CODE_W(2), .CODES_PER_BEAT(4), .OUT_W(8), .BEAT_W(2)) bus ();
    lut_code_unpacker_if #(.NUM_CODES(16), .CODE_W(2), .CODES_PER_BEAT(4), .OUT_W(8), .BEAT_W(2)) bus2 ();

    lut_code_unpacker #(.NUM_CODES(16), .CODE_W(2), .CODES_PER_BEAT(4), .OUT_W(8), .STEP(32), .OFFSET(16))
        dut (.clk(clk), .rst(rst), .bus(bus));

    lut_code_unpacker #(.NUM_CODES(16), .CODE_W(2), .CODES_PER_BEAT(4), .OUT_W(8), .STEP(100), .OFFSET(200))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        checks++; if (bus.out_data !== 32'h0000_0000) begin errors++; $display("FAIL reset_out_data got %h exp 00000000", bus.out_data); end
        checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b exp 0", bus.out_last); end
        checks++; if (bus.out_beat !== 2'd0) begin errors++; $display("FAIL reset_out_beat got %0d exp 0", bus.out_beat); end
        rst = 1'b0;
        step();
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b exp 1", bus.in_ready); end
    endtask

    task automatic test_single();
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hE4E4_E4E4;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.in_data  = 32'h0;
        for (int b = 0; b < 4; b++) begin
            #1;
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid beat %0d got %b exp 1", b, bus.out_valid); end
            checks++; if (bus.out_data !== 32'h7050_3010) begin errors++; $display("FAIL single_data beat %0d got %h exp 70503010", b, bus.out_data); end
            checks++; if (bus.out_beat !== 2'(b)) begin errors++; $display("FAIL single_beat got %0d exp %0d", bus.out_beat, b); end
            checks++; if (bus.out_last !== (b == 3)) begin errors++; $display("FAIL single_last beat %0d got %b exp %b", b, bus.out_last, (b == 3)); end
            checks++; if (bus.in_ready !== (b == 3)) begin errors++; $display("FAIL single_in_ready beat %0d got %b exp %b", b, bus.in_ready, (b == 3)); end
            step();
        end
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_drop_valid got %b exp 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL single_idle_ready got %b exp 1", bus.in_ready); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_a [4];
        exp_a[0] = 32'h7070_7070;
        exp_a[1] = 32'h1010_1010;
        exp_a[2] = 32'h1010_1010;
        exp_a[3] = 32'h1010_1010;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h0000_00FF;
        bus.out_ready = 1'b1;
        step();
        bus.in_data = 32'hFFFF_FFFF;
        for (int b = 0; b < 4; b++) begin
            #1;
            checks++; if (bus.out_data !== exp_a[b]) begin errors++; $display("FAIL b2b_a_data beat %0d got %h exp %h", b, bus.out_data, exp_a[b]); end
            checks++; if (bus.out_beat !== 2'(b)) begin errors++; $display("FAIL b2b_a_beat got %0d exp %0d", bus.out_beat, b); end
            checks++; if (bus.in_ready !== (b == 3)) begin errors++; $display("FAIL b2b_a_in_ready beat %0d got %b exp %b", b, bus.in_ready, (b == 3)); end
            step();
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 32'h0;
        for (int b = 0; b < 4; b++) begin
            #1;
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_b_valid beat %0d got %b exp 1", b, bus.out_valid); end
            checks++; if (bus.out_data !== 32'h7070_7070) begin errors++; $display("FAIL b2b_b_data beat %0d got %h exp 70707070", b, bus.out_data); end
            checks++; if (bus.out_beat !== 2'(b)) begin errors++; $display("FAIL b2b_b_beat got %0d exp %0d", bus.out_beat, b); end
            step();
        end
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drop_valid got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_stall();
        logic [31:0] exp_a [4];
        logic [39:0] pat;
        int idx;
        exp_a[0] = 32'h7070_7070;
        exp_a[1] = 32'h1010_1010;
        exp_a[2] = 32'h1010_1010;
        exp_a[3] = 32'h1010_1010;
        pat = 40'h96_5A_C3_A5_36;
        idx = 0;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h0000_00FF;
        bus.out_ready = 1'b0;
        step();
        bus.in_valid = 1'b0;
        bus.in_data  = 32'h0;
        for (int i = 0; i < 40 && idx < 4; i++) begin
            bus.out_ready = pat[i];
            #1;
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid cycle %0d got %b exp 1", i, bus.out_valid); end
            checks++; if (bus.out_data !== exp_a[idx]) begin errors++; $display("FAIL stall_data cycle %0d got %h exp %h", i, bus.out_data, exp_a[idx]); end
            checks++; if (bus.out_beat !== 2'(idx)) begin errors++; $display("FAIL stall_beat cycle %0d got %0d exp %0d", i, bus.out_beat, idx); end
            if (!pat[i]) begin
                checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cycle %0d got %b exp 0", i, bus.in_ready); end
            end
            if (pat[i]) idx++;
            step();
        end
        checks++; if (idx != 4) begin errors++; $display("FAIL stall_budget beats %0d exp 4", idx); end
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_drop_valid got %b exp 0", bus.out_valid); end
        bus.out_ready = 1'b1;
    endtask

    task automatic test_ignore();
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hE4E4_E4E4;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h1B1B_1B1B;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL ignore_in_ready got %b exp 0", bus.in_ready); end
            checks++; if (bus.out_data !== 32'h7050_3010) begin errors++; $display("FAIL ignore_hold_data got %h exp 70503010", bus.out_data); end
            checks++; if (bus.out_beat !== 2'd1) begin errors++; $display("FAIL ignore_hold_beat got %0d exp 1", bus.out_beat); end
            step();
        end
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.in_data  = 32'h0;
        for (int b = 2; b < 4; b++) begin
            #1;
            checks++; if (bus.out_data !== 32'h7050_3010) begin errors++; $display("FAIL ignore_data beat %0d got %h exp 70503010", b, bus.out_data); end
            checks++; if (bus.out_beat !== 2'(b)) begin errors++; $display("FAIL ignore_beat got %0d exp %0d", bus.out_beat, b); end
            step();
        end
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ignore_drop_valid got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h0000_00FF;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        #1;
        checks++; if (bus.out_beat !== 2'd2) begin errors++; $display("FAIL rstmid_pre_beat got %0d exp 2", bus.out_beat); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b exp 1", bus.in_ready); end
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hFFFF_FFFF;
        step();
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.out_beat !== 2'd0) begin errors++; $display("FAIL rstmid_restart_beat got %0d exp 0", bus.out_beat); end
        checks++; if (bus.out_data !== 32'h7070_7070) begin errors++; $display("FAIL rstmid_restart_data got %h exp 70707070", bus.out_data); end
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_override();
        @(negedge clk);
        bus2.in_valid  = 1'b1;
        bus2.in_data   = 32'hE4E4_E4E4;
        bus2.out_ready = 1'b1;
        step();
        bus2.in_valid = 1'b0;
        #1;
        checks++; if (bus2.out_data !== 32'hF490_2CC8) begin errors++; $display("FAIL override_data got %h exp f4902cc8", bus2.out_data); end
        checks++; if (bus2.out_data[31:24] !== 8'hF4) begin errors++; $display("FAIL override_code3 got %h exp f4", bus2.out_data[31:24]); end
        for (int i = 0; i < 4; i++) step();
        #1;
        checks++; if (bus2.out_valid !== 1'b0) begin errors++; $display("FAIL override_drop_valid got %b exp 0", bus2.out_valid); end
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_data    = 32'h0;
        bus.out_ready  = 1'b0;
        bus2.in_valid  = 1'b0;
        bus2.in_data   = 32'h0;
        bus2.out_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_ignore();
        test_reset_mid();
        test_override();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "bench time limit");
    end

endmodule
